// File: rtl/pwm_width_meter.sv
// Measures high-time and rising-to-rising period of an asynchronous PWM line in
// clk100 cycles, publishing one result per period and flagging a stuck line.
module pwm_width_meter #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000000
) (
  input  logic             clk100,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_FULL = IDLE_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s;
  logic                   pwm_d;
  logic                   rise;
  logic                   fall;
  logic                   rise_q;
  logic                   fall_q;
  logic                   level_q;
  logic [1:0]             state;
  logic [CNT_W-1:0]       hcnt;
  logic [CNT_W-1:0]       pcnt;
  logic [CNT_W-1:0]       pend_width;
  logic [CNT_W-1:0]       pend_period;
  logic                   pend_valid;
  logic [IDLE_W-1:0]      idle_cnt;
  logic                   edge_seen;
  logic                   timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign pwm_s     = sync_q[SYNC_STAGES-1];
  assign rise      = pwm_s & ~pwm_d;
  assign fall      = ~pwm_s & pwm_d;
  assign edge_seen = rise_q | fall_q;
  assign timeout   = ~edge_seen && (idle_cnt == IDLE_LAST);

  // Edges are registered together with the line level so the FSM, the counters
  // and the timeout all see one consistent, aligned view of the line.
  always_ff @(posedge clk100) begin
    if (rst) begin
      sync_q  <= '0;
      pwm_d   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_d   <= pwm_s;
      rise_q  <= rise;
      fall_q  <= fall;
      level_q <= pwm_s;
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      idle_cnt   <= '0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else if (edge_seen) begin
      idle_cnt   <= '0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      if (idle_cnt != IDLE_FULL) idle_cnt <= idle_cnt + 1'b1;
      if (timeout) begin
        stuck_high <= level_q;
        stuck_low  <= ~level_q;
      end
    end
  end

  // The closing rise of a period publishes the counts and opens the next
  // period with that rise cycle already counted.
  always_ff @(posedge clk100) begin
    if (rst) begin
      state       <= S_IDLE;
      hcnt        <= '0;
      pcnt        <= '0;
      pend_width  <= '0;
      pend_period <= '0;
      pend_valid  <= 1'b0;
    end else begin
      pend_valid <= 1'b0;
      if (timeout) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (rise_q) begin
              state <= S_HIGH;
              hcnt  <= CNT_ONE;
              pcnt  <= CNT_ONE;
            end
          end
          S_HIGH: begin
            pcnt <= sat_inc(pcnt);
            if (fall_q) state <= S_LOW;
            else        hcnt  <= sat_inc(hcnt);
          end
          S_LOW: begin
            if (rise_q) begin
              pend_width  <= hcnt;
              pend_period <= pcnt;
              pend_valid  <= 1'b1;
              state       <= S_HIGH;
              hcnt        <= CNT_ONE;
              pcnt        <= CNT_ONE;
            end else begin
              pcnt <= sat_inc(pcnt);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      width      <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= pend_valid;
      if (pend_valid) begin
        width  <= pend_width;
        period <= pend_period;
      end
    end
  end

endmodule
